// File: rtl/fb_pkg.sv
// Shared constants and FSM state type for the frame-buffer write path.
// Geometry defaults describe the 320x240 RGB444 frame buffer.
package fb_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int FB_DATA_W = 12;
  localparam int FB_ADDR_W = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fb_raster_counter.sv
// Raster position counter: x/y plus linear address, with restart and last-pixel flag.
// restart marks the current beat as position (0,0), so the counters move on to (1,0).
module fb_raster_counter #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17,
  parameter int X_W    = $clog2(WIDTH),
  parameter int Y_W    = $clog2(HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  // Position registers; wrapping after the last pixel returns all counters to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (restart) begin
      x    <= X_W'(1);
      y    <= '0;
      addr <= ADDR_W'(1);
    end else if (en) begin
      if (x == X_W'(WIDTH - 1)) begin
        x <= '0;
        if (y == Y_W'(HEIGHT - 1)) begin
          y    <= '0;
          addr <= '0;
        end else begin
          y    <= y + Y_W'(1);
          addr <= addr + ADDR_W'(1);
        end
      end else begin
        x    <= x + X_W'(1);
        addr <= addr + ADDR_W'(1);
      end
    end
  end

  assign last = (x == X_W'(WIDTH - 1)) && (y == Y_W'(HEIGHT - 1));

endmodule

// File: rtl/fb_pixel_writer.sv
// Frame-buffer write side: raster pixel stream in, registered BRAM write port out.
// Optional FB_PIXEL_WRITER_DECIMATE_EN: accept a 2x-size raster and keep every even (x,y) pixel.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int DATA_W = FB_DATA_W,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sof,
  input  logic [DATA_W-1:0] s_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int X_W = $clog2(WIDTH);
  localparam int Y_W = $clog2(HEIGHT);

  fb_state_t         state;
  fb_state_t         next_state;
  logic              accept;
  logic              restart;
  logic              advance;
  logic              out_en;
  logic              do_write;
  logic              done_hit;
  logic              err_hit;
  logic [X_W-1:0]    out_x;
  logic [Y_W-1:0]    out_y;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic [ADDR_W-1:0] write_addr;
  logic              unused_bits;

  assign accept     = s_valid && s_ready;
  // Any accepted s_sof restarts the frame; only in WRITE is it an error.
  assign restart    = accept && s_sof;
  assign err_hit    = restart && (state == WRITE);
  assign advance    = accept && !s_sof && (state == WRITE);
  assign do_write   = restart || out_en;
  assign write_addr = restart ? '0 : out_addr;

  fb_raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_out_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (out_en),
    .restart (restart),
    .x       (out_x),
    .y       (out_y),
    .addr    (out_addr),
    .last    (out_last)
  );

`ifdef FB_PIXEL_WRITER_DECIMATE_EN
  localparam int SX_W = $clog2(2 * WIDTH);
  localparam int SY_W = $clog2(2 * HEIGHT);

  logic [SX_W-1:0]   sx;
  logic [SY_W-1:0]   sy;
  logic [ADDR_W+1:0] src_addr;
  logic              src_last;

  fb_raster_counter #(
    .WIDTH  (2 * WIDTH),
    .HEIGHT (2 * HEIGHT),
    .ADDR_W (ADDR_W + 2)
  ) u_src_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (advance),
    .restart (restart),
    .x       (sx),
    .y       (sy),
    .addr    (src_addr),
    .last    (src_last)
  );

  // Only even source columns of even source rows land in the frame buffer.
  assign out_en      = advance && !sx[0] && !sy[0];
  assign done_hit    = advance && src_last;
  assign unused_bits = ^{out_x, out_y, out_last, src_addr, sx[SX_W-1:1], sy[SY_W-1:1]};
`else
  assign out_en      = advance;
  assign done_hit    = advance && out_last;
  assign unused_bits = ^{out_x, out_y};
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (restart) begin
          next_state = WRITE;
        end else begin
          next_state = IDLE;
        end
      end
      WRITE: begin
        if (done_hit) begin
          next_state = DONE;
        end else begin
          next_state = WRITE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    s_ready = 1'b1;
    busy    = 1'b0;
    case (state)
      IDLE:    begin s_ready = 1'b1; busy = 1'b0; end
      WRITE:   begin s_ready = 1'b1; busy = 1'b1; end
      DONE:    begin s_ready = 1'b0; busy = 1'b0; end
      default: begin s_ready = 1'b0; busy = 1'b0; end
    endcase
  end

  // Registered write port and status pulses; address/data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_en      <= do_write;
      frame_done <= done_hit;
      frame_err  <= err_hit;
      if (do_write) begin
        wr_addr <= write_addr;
        wr_data <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer on a reduced 32x24 raster (768 pixels).
// Follows FB_PIXEL_WRITER_DECIMATE_EN: with it defined the source raster is 64x48.
module tb_fb_pixel_writer;

  localparam int TW = 32;
  localparam int TH = 24;
`ifdef FB_PIXEL_WRITER_DECIMATE_EN
  localparam int SW = 2 * TW;
  localparam int SH = 2 * TH;
`else
  localparam int SW = TW;
  localparam int SH = TH;
`endif
  localparam int SRC_PIX = SW * SH;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic [11:0] s_data = 12'd0;
  logic        s_ready;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        frame_done;
  logic        frame_err;
  logic        busy;

  fb_pixel_writer #(
    .WIDTH  (TW),
    .HEIGHT (TH),
    .DATA_W (12),
    .ADDR_W (17)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_sof      (s_sof),
    .s_data     (s_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: frame position as a plain source-beat index.
  bit        m_in_frame;
  bit        m_done_prev;
  int        m_p;
  bit        exp_wr_en;
  bit [16:0] exp_wr_addr;
  bit [11:0] exp_wr_data;
  bit        exp_done;
  bit        exp_err;

  function automatic bit m_writes(input int p);
`ifdef FB_PIXEL_WRITER_DECIMATE_EN
    return ((p % SW) % 2 == 0) && ((p / SW) % 2 == 0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int m_addr(input int p);
`ifdef FB_PIXEL_WRITER_DECIMATE_EN
    return ((p / SW) / 2) * TW + (p % SW) / 2;
`else
    return p;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in_frame  <= 1'b0;
      m_done_prev <= 1'b0;
      m_p         <= 0;
      exp_wr_en   <= 1'b0;
      exp_wr_addr <= '0;
      exp_wr_data <= '0;
      exp_done    <= 1'b0;
      exp_err     <= 1'b0;
    end else begin
      exp_wr_en   <= 1'b0;
      exp_done    <= 1'b0;
      exp_err     <= 1'b0;
      m_done_prev <= 1'b0;
      if (s_valid && !m_done_prev) begin
        if (s_sof) begin
          exp_err     <= m_in_frame;
          m_in_frame  <= 1'b1;
          m_p         <= 1;
          exp_wr_en   <= 1'b1;
          exp_wr_addr <= '0;
          exp_wr_data <= s_data;
        end else if (m_in_frame) begin
          if (m_writes(m_p)) begin
            exp_wr_en   <= 1'b1;
            exp_wr_addr <= 17'(m_addr(m_p));
            exp_wr_data <= s_data;
          end
          if (m_p == SRC_PIX - 1) begin
            exp_done    <= 1'b1;
            m_in_frame  <= 1'b0;
            m_done_prev <= 1'b1;
            m_p         <= 0;
          end else begin
            m_p <= m_p + 1;
          end
        end
      end
    end
  end

  int        n_checks = 0;
  int        n_fail = 0;
  int        wr_cnt, done_cnt, err_cnt, rdy_low;
  int        done_addr, err_addr, post_err_addr, probe_addr;
  bit        done_wren, want_post;
  bit [11:0] probe_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    wr_cnt = 0; done_cnt = 0; err_cnt = 0; rdy_low = 0;
    done_addr = -1; err_addr = -1; post_err_addr = -1; probe_addr = -1;
    done_wren = 1'b0; want_post = 1'b0;
  endtask

  // Per-cycle comparison of every DUT output against the model, plus statistics.
  task automatic compare();
    check("wr_en", {31'd0, wr_en}, {31'd0, exp_wr_en});
    check("wr_addr", {15'd0, wr_addr}, {15'd0, exp_wr_addr});
    check("wr_data", {20'd0, wr_data}, {20'd0, exp_wr_data});
    check("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
    check("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
    check("busy", {31'd0, busy}, {31'd0, m_in_frame});
    check("s_ready", {31'd0, s_ready}, {31'd0, !m_done_prev});
    if (wr_en) begin
      wr_cnt++;
      if (want_post && !frame_err) begin
        post_err_addr = int'(wr_addr);
        want_post = 1'b0;
      end
      if (wr_data == probe_data) probe_addr = int'(wr_addr);
    end
    if (frame_done) begin
      done_cnt++;
      done_addr = int'(wr_addr);
      done_wren = wr_en;
    end
    if (frame_err) begin
      err_cnt++;
      err_addr = int'(wr_addr);
      want_post = 1'b1;
    end
    if (!s_ready) rdy_low++;
  endtask

  task automatic step(input bit v, input bit sof, input logic [11:0] d);
    s_valid = v;
    s_sof   = sof;
    s_data  = d;
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {15'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {20'd0, wr_data}, 32'd0);
    check("rst_done_err", {30'd0, frame_done, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    step(1'b0, 1'b0, 12'd0);
    rst = 1'b0;
  endtask

  // Drive one frame; duty = percent of cycles with s_valid, data = source index or random.
  task automatic send_frame(input int duty, input int sof_again, input int rst_at, input bit rand_data);
    int  p = 0;
    int  guard = 0;
    bit  restarted = 1'b0;
    bit  sof;
    logic [11:0] d;
    while (p < SRC_PIX && guard < 40000) begin
      guard++;
      if (p == rst_at) begin
        async_reset();
        return;
      end
      if ($urandom_range(99) >= duty) begin
        step(1'b0, 1'b0, 12'($urandom));
        continue;
      end
      sof = (p == 0);
      if (!restarted && sof_again > 0 && p == sof_again) begin
        restarted = 1'b1;
        p = 0;
        sof = 1'b1;
      end
      d = rand_data ? 12'($urandom) : 12'(p);
      step(1'b1, sof, d);
      p++;
    end
    check("frame_budget", {31'd0, guard < 40000}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'd0);
  endtask

  initial begin
    probe_data = 12'hFFF;
    clear_stats();
    #1 rst = 1'b1;
    @(negedge clk);
    compare();
    step(1'b0, 1'b0, 12'd0);
    rst = 1'b0;

    // Reset state, then beats without s_sof are dropped in IDLE.
    check("reset_wr_addr", {15'd0, wr_addr}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 12'($urandom));
    check("idle_no_write", wr_cnt, 32'd0);
    check("idle_ready", {31'd0, s_ready}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Gap-free frame, data = source index.
    clear_stats();
`ifdef FB_PIXEL_WRITER_DECIMATE_EN
    probe_data = 12'd130;
`else
    probe_data = 12'd163;
`endif
    send_frame(100, 0, -1, 1'b0);
    check("f1_writes", wr_cnt, 32'd768);
    check("f1_done_cnt", done_cnt, 32'd1);
    check("f1_done_addr", done_addr, 32'd767);
    check("f1_ready_low", rdy_low, 32'd1);
`ifdef FB_PIXEL_WRITER_DECIMATE_EN
    check("f1_done_wren", {31'd0, done_wren}, 32'd0);
    check("f1_src22_addr", probe_addr, 32'd33);
`else
    check("f1_done_wren", {31'd0, done_wren}, 32'd1);
    check("f1_probe_addr", probe_addr, 32'd163);
`endif

    // Same frame with ~50% valid gaps.
    clear_stats();
    send_frame(50, 0, -1, 1'b0);
    check("f2_writes", wr_cnt, 32'd768);
    check("f2_done_cnt", done_cnt, 32'd1);
    check("f2_done_addr", done_addr, 32'd767);
    check("f2_ready_low", rdy_low, 32'd1);

    // Mid-frame s_sof at source beat 100, random data, random gaps.
    clear_stats();
    probe_data = 12'hFFF;
    send_frame(70, 100, -1, 1'b1);
    check("f3_err_cnt", err_cnt, 32'd1);
    check("f3_err_addr", err_addr, 32'd0);
    check("f3_post_err_addr", post_err_addr, 32'd1);
    check("f3_done_cnt", done_cnt, 32'd1);
`ifndef FB_PIXEL_WRITER_DECIMATE_EN
    check("f3_writes", wr_cnt, 32'd868);
`endif

    // Asynchronous reset at source beat 50; next frame needs s_sof.
    clear_stats();
    send_frame(100, 0, 50, 1'b0);
    clear_stats();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 12'($urandom));
    check("post_rst_no_write", wr_cnt, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    send_frame(80, 0, -1, 1'b1);
    check("f5_writes", wr_cnt, 32'd768);
    check("f5_done_cnt", done_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
